// File: rtl/reg_file_swap.sv
// Register file with one synchronous write port, one asynchronous read port and
// a swap engine that exchanges the contents of two addresses in three cycles.
//
// Swap handshake: swap_req is a level that the requester holds until the swap is
// accepted. A swap is accepted on a posedge where the engine is IDLE, swap_req is
// high and we is low. swap_busy is high while a swap is in flight. swap_done
// pulses for one cycle when the swap completes. An external write attempted while
// busy is discarded and reported with a one-cycle wr_drop pulse.
module reg_file_swap #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr_w,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] addr_r,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  swap_req,
  input  logic [ADDR_WIDTH-1:0] swap_addr_a,
  input  logic [ADDR_WIDTH-1:0] swap_addr_b,
  output logic                  swap_busy,
  output logic                  swap_done,
  output logic                  wr_drop
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_A = 2'd1,
    WR_B = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] tmp_a;
  logic [DATA_WIDTH-1:0] tmp_b;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic                  accept;

  // An external write in the same cycle wins over a pending swap request.
  assign accept    = (state == IDLE) && swap_req && !we;
  assign swap_busy = (state != IDLE);
  assign rd_data   = mem[addr_r];

  // Next-state logic for the swap engine.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = WR_A;
      WR_A:    state_next = WR_B;
      WR_B:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Capture both operands and addresses at accept so the swap uses a consistent snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmp_a  <= '0;
      tmp_b  <= '0;
      addr_a <= '0;
      addr_b <= '0;
    end else if (accept) begin
      tmp_a  <= mem[swap_addr_a];
      tmp_b  <= mem[swap_addr_b];
      addr_a <= swap_addr_a;
      addr_b <= swap_addr_b;
    end
  end

  // One-cycle status pulses: completion and discarded external write.
  always_ff @(posedge clk) begin
    if (rst) begin
      swap_done <= 1'b0;
      wr_drop   <= 1'b0;
    end else begin
      swap_done <= (state == WR_B);
      wr_drop   <= we && (state != IDLE);
    end
  end

  // Array write port; reset blocks every write, so a swap aborted in WR_B
  // leaves mem[b] holding its old value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      case (state)
        IDLE:    if (we) mem[addr_w] <= wr_data;
        WR_A:    mem[addr_a] <= tmp_b;
        WR_B:    mem[addr_b] <= tmp_a;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_swap.sv
// Self-checking bench for reg_file_swap: directed scenarios followed by random
// writes, reads and swaps, all checked against an array model of the memory.
module tb_reg_file_swap;

  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          we;
  logic [AW-1:0] addr_w;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] rd_data;
  logic          swap_req;
  logic [AW-1:0] swap_addr_a;
  logic [AW-1:0] swap_addr_b;
  logic          swap_busy;
  logic          swap_done;
  logic          wr_drop;

  reg_file_swap #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .we(we), .addr_w(addr_w), .wr_data(wr_data),
    .addr_r(addr_r), .rd_data(rd_data), .swap_req(swap_req),
    .swap_addr_a(swap_addr_a), .swap_addr_b(swap_addr_b),
    .swap_busy(swap_busy), .swap_done(swap_done), .wr_drop(wr_drop)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];   // expected rd_data values
  logic [2:0]    flag_q[$];  // expected {swap_busy, swap_done, wr_drop}
  logic [DW-1:0] model_mem [DEPTH];
  bit            chk_rd;
  bit            chk_fl;
  int            n_cmp;
  int            n_bad;
  int            done_exp;
  int            done_seen;

  // ---------------- monitor ----------------
  // Samples mid-cycle: outputs have settled after the posedge and after the
  // driver's input changes.
  always @(negedge clk) begin
    if (swap_done) done_seen++;
    if (chk_rd) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_data: no expectation queued, got %02h", rd_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_bad++;
          $display("FAIL rd_data addr %0d: got %02h expected %02h at %0t", addr_r, rd_data, e, $time);
        end
      end
    end
    if (chk_fl) begin
      n_cmp++;
      if (flag_q.size() == 0) begin
        n_bad++;
        $display("FAIL flags: no expectation queued");
      end else begin
        logic [2:0] f;
        f = flag_q.pop_front();
        if ({swap_busy, swap_done, wr_drop} !== f) begin
          n_bad++;
          $display("FAIL flags busy/done/drop: got %b%b%b expected %b at %0t",
                   swap_busy, swap_done, wr_drop, f, $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One clock cycle with the inputs already set; optionally queue checks for
  // the mid-cycle sample of this cycle.
  task automatic cyc(input bit fl_en, input logic [2:0] fl_exp,
                     input bit rd_en, input logic [DW-1:0] rd_exp);
    if (fl_en) begin flag_q.push_back(fl_exp); chk_fl = 1'b1; end
    if (rd_en) begin exp_q.push_back(rd_exp); chk_rd = 1'b1; end
    @(posedge clk);
    #1;
    chk_fl = 1'b0;
    chk_rd = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; addr_w = a; wr_data = d;
    cyc(0, 3'b000, 0, '0);
    we = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    addr_r = a;
    cyc(0, 3'b000, 1, model_mem[a]);
  endtask

  // Full swap: accept cycle, WR_A, WR_B, done cycle, then one cycle checking the
  // pulse has cleared. poke: attempt an external write during WR_A. hold: keep
  // swap_req high with scrambled addresses while busy (must be ignored).
  task automatic do_swap(input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input bit poke, input bit hold);
    logic [DW-1:0] old_a;
    logic [DW-1:0] old_b;
    old_a = model_mem[a];
    old_b = model_mem[b];
    swap_req = 1'b1; swap_addr_a = a; swap_addr_b = b;
    cyc(1, 3'b000, 0, '0);                       // accepted at this edge
    if (!hold) swap_req = 1'b0;
    swap_addr_a = AW'($urandom_range(0, DEPTH-1));
    swap_addr_b = AW'($urandom_range(0, DEPTH-1));
    if (poke) begin
      we = 1'b1; addr_w = a; wr_data = ~old_a;
    end
    addr_r = a;
    cyc(1, 3'b100, 1, old_a);                    // WR_A: mem[a] not yet written
    we = 1'b0;
    addr_r = b;
    cyc(1, poke ? 3'b101 : 3'b100, 1, (a == b) ? old_a : old_b); // WR_B
    swap_req = 1'b0;
    model_mem[a] = old_b;
    model_mem[b] = old_a;
    addr_r = a;
    cyc(1, 3'b010, 1, model_mem[a]);             // done pulse, engine idle
    done_exp++;
    addr_r = b;
    cyc(1, 3'b000, 1, model_mem[b]);             // pulse cleared
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; we = 1'b0; addr_w = '0; wr_data = '0; addr_r = '0;
    swap_req = 1'b0; swap_addr_a = '0; swap_addr_b = '0;
    chk_rd = 1'b0; chk_fl = 1'b0;
    n_cmp = 0; n_bad = 0; done_exp = 0; done_seen = 0;

    // T1: reset for two cycles, outputs quiet after release
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1, 3'b000, 0, '0);
    cyc(1, 3'b000, 0, '0);

    // Give every word a known value so random reads are always defined.
    for (int i = 0; i < DEPTH; i++) do_write(AW'(i), DW'($urandom_range(0, 255)));

    // T2: write then read
    do_write(7'd5, 8'h3C);
    do_read(7'd5);

    // T3: basic swap
    do_write(7'd2, 8'h11);
    do_write(7'd9, 8'hA5);
    do_swap(7'd2, 7'd9, 0, 0);
    do_read(7'd2);
    do_read(7'd9);

    // T4: write and request together; write lands, swap accepted next cycle
    swap_req = 1'b1; swap_addr_a = 7'd4; swap_addr_b = 7'd6;
    do_write(7'd4, 8'h77);
    do_swap(7'd4, 7'd6, 0, 0);
    do_read(7'd6);

    // T5: write during WR_A is dropped; then a degenerate a==b swap
    do_swap(7'd3, 7'd8, 1, 0);
    do_read(7'd3);
    do_swap(7'd7, 7'd7, 0, 0);
    do_read(7'd7);

    // Requests held while busy are ignored, latched addresses are used
    do_swap(7'd10, 7'd20, 0, 1);

    // T6: reset during WR_B; WR_A result stays, WR_B write never happens
    do_write(7'd2, 8'h11);
    do_write(7'd9, 8'hA5);
    swap_req = 1'b1; swap_addr_a = 7'd2; swap_addr_b = 7'd9;
    cyc(1, 3'b000, 0, '0);
    swap_req = 1'b0;
    cyc(1, 3'b100, 0, '0);                       // WR_A executes at this edge
    rst = 1'b1;
    cyc(1, 3'b100, 0, '0);                       // in WR_B, reset at the edge
    rst = 1'b0;
    model_mem[2] = 8'hA5;                        // mem[a] took old mem[b]
    cyc(1, 3'b000, 0, '0);
    cyc(1, 3'b000, 0, '0);
    do_read(7'd2);
    do_read(7'd9);

    // Random phase
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0: do_write(AW'($urandom_range(0, DEPTH-1)), DW'($urandom_range(0, 255)));
        1: do_read(AW'($urandom_range(0, DEPTH-1)));
        2: do_swap(AW'($urandom_range(0, DEPTH-1)), AW'($urandom_range(0, DEPTH-1)),
                   bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        default: begin
          logic [AW-1:0] s;
          s = AW'($urandom_range(0, DEPTH-1));
          do_swap(s, s, 0, bit'($urandom_range(0, 1)));
        end
      endcase
    end

    // Final sweep of the whole array against the model
    for (int i = 0; i < DEPTH; i++) do_read(AW'(i));

    @(negedge clk); #1;
    n_cmp++;
    if (done_seen != done_exp) begin
      n_bad++;
      $display("FAIL done_count: got %0d pulses expected %0d", done_seen, done_exp);
    end
    n_cmp++;
    if (exp_q.size() + flag_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size() + flag_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
